riscv_trace_uart_tx: RTL and testbench
======================================

# riscv_trace_uart_tx

Execution-trace transmitter for the riscv32i SOC. It watches the core's state, PC and instruction outputs and captures a {PC, INSTR} record each time the core enters the execute state. Records are buffered in a small FIFO and serialized as framed bytes over a UART 8N1 line, so a host or bench UART receiver can rebuild the same trace the simulation bench prints. It sits beside the SOC on the state_out/pc_out/instr_out taps and drives a single pin.

## Interface
- CLKS_PER_BIT, 4 — clock cycles per UART bit; legal values ≥ 2.
- DEPTH, 4 — FIFO depth in records; power of two, ≥ 2.
- EXEC_STATE, 3'd3 — core state value that triggers a capture.
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  reset, synchronous, active-low: 0 = reset.
- state_in  in  3  core FSM state (SOC state_out).
- pc_in  in  32  core PC (SOC pc_out).
- instr_in  in  32  core instruction (SOC instr_out).
- tx  out  1  UART line, idle high.
- busy  out  1  high while a frame is being sent.
- overflow  out  1  sticky; a record was dropped because the FIFO was full.

## Operation
- Capture: prev_state register, reset value 3'd0. A capture fires on an edge where state_in == EXEC_STATE and prev_state != EXEC_STATE. That edge writes {pc_in, instr_in} to the FIFO. A steady EXEC_STATE gives exactly one record.
- FIFO full at capture, no pop that edge: the record is dropped and overflow is set. A capture and a pop on the same edge while full is accepted; no drop.
- Frame: 9 bytes. Sync byte 0xA5, then PC[31:24], PC[23:16], PC[15:8], PC[7:0], then INSTR in the same MSB-first byte order.
- Byte format: start bit 0, data bits LSB first, stop bit 1. Each bit lasts CLKS_PER_BIT cycles.
- TX FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop a record into the 64-bit shift register, clear the byte index, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte index < 8, increment it and go to START; otherwise go to IDLE.
- busy = (FSM != IDLE).
- Reset values:
  - Outputs: tx=1, busy=0, overflow=0.
  - FIFO empty, FSM IDLE, bit and baud counters 0.
  - A reset mid-frame aborts the frame at once: tx returns to 1 on the reset edge and buffered records are discarded.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is clog2(CLKS_PER_BIT). Pointers are clog2(DEPTH) bits and wrap; the count is clog2(DEPTH)+1 bits.

## Timing
- Capture edge N → record in FIFO after N. The IDLE pop happens at edge N+1, and tx falls (start bit) after edge N+2, assuming the FSM was idle.
- Frame length: 90·CLKS_PER_BIT cycles from start-bit fall to the end of the last stop bit.
- Back-to-back frames have exactly one IDLE cycle (tx=1) between the last stop bit and the next start bit.
- Sustained capture rate without loss: one record per 90·CLKS_PER_BIT+1 cycles, plus DEPTH records of burst.

## Configuration
- TRACE_LOSS_MARK_EN defined:
  - A pending-loss flag is set on every dropped record.
  - The next frame popped carries sync byte 0x5A instead of 0xA5.
  - The flag clears when that frame's sync byte is loaded. The overflow output stays sticky.
- Undefined: no flag is kept, and every frame uses 0xA5.

## Structure
- Package riscy_trace_pkg holds:
  - The EXEC_STATE default.
  - Constants SYNC_OK = 8'hA5 and SYNC_LOSS = 8'h5A.
  - Frame length 9.
  - The TX FSM state enum.
- Sub-module trace_fifo:
  - Synchronous, DEPTH×64 bits.
  - Ports: push, pop, din, dout, full, empty.
  - Same-edge push and pop while full is legal.

## Test plan (CLKS_PER_BIT=4, DEPTH=4)
- Reset for 2 cycles, then idle → tx=1, busy=0, overflow=0 throughout.
- state_in 2→3 with pc_in=0x00000010 and instr_in=0x00A00093, held at 3 for 20 cycles → exactly one frame, bytes A5 00 00 00 10 00 A0 00 93. tx falls 2 cycles after the capture edge, and the frame lasts 360 cycles.
- Six captures 10 cycles apart → first frame popped, four buffered, sixth dropped. overflow=1; five frames sent with one idle cycle between each.
- With TRACE_LOSS_MARK_EN, repeat the previous scenario → the frame after the drop begins 0x5A, and later frames begin 0xA5.
- RESET low mid-frame (byte 4) → tx=1 on the next edge and busy=0. After release, no frame resumes until a new capture.
- Capture on the same edge as an IDLE pop with the FIFO full → no drop, and overflow stays 0.

Source files
------------

// File: rtl/riscy_trace_pkg.sv
// Shared constants and TX state encoding for the execution-trace UART.
// Optional feature: TRACE_LOSS_MARK_EN (marks the frame after a dropped record).
package riscy_trace_pkg;
  localparam logic [2:0] EXEC_STATE_DEF = 3'd3;
  localparam logic [7:0] SYNC_OK        = 8'hA5;
  localparam logic [7:0] SYNC_LOSS      = 8'h5A;
  localparam int         FRAME_BYTES    = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;
endpackage

// File: rtl/trace_fifo.sv
// Synchronous DEPTH x W record FIFO with show-ahead read data.
// Push and pop on the same edge are legal even when full.
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end
endmodule

// File: rtl/riscv_trace_uart_tx.sv
// Captures {PC, INSTR} on entry to EXEC_STATE and sends 9-byte UART 8N1 frames.
// Define TRACE_LOSS_MARK_EN to send sync 0x5A on the frame after a drop.
module riscv_trace_uart_tx
  import riscy_trace_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 4,
  parameter int         DEPTH        = 4,
  parameter logic [2:0] EXEC_STATE   = EXEC_STATE_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  state_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

  logic [2:0]  prev_state;
  logic        capture;
  logic        push;
  logic        pop;
  logic        drop;
  logic        full;
  logic        empty;
  logic [63:0] dout;

  tx_state_e   state;
  tx_state_e   state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_d;
  logic [3:0]  byte_idx;
  logic [3:0]  byte_d;
  logic [63:0] sreg;
  logic [63:0] sreg_d;
  logic [7:0]  sync_q;
  logic [7:0]  sync_d;
  logic [7:0]  sync_sel;
  logic [7:0]  cur_byte;
  logic        baud_end;
  logic        tx_d;

  assign capture  = (state_in == EXEC_STATE) && (prev_state != EXEC_STATE);
  assign push     = capture && (!full || pop);
  assign drop     = capture && full && !pop;
  assign busy     = (state != S_IDLE);
  assign baud_end = (cnt == CMAX);
  assign cur_byte = (byte_idx == 4'd0) ? sync_q : sreg[63:56];

  trace_fifo #(
    .DEPTH(DEPTH),
    .W    (64)
  ) u_fifo (
    .clk  (CLK),
    .rst_n(RESET),
    .push (push),
    .pop  (pop),
    .din  ({pc_in, instr_in}),
    .dout (dout),
    .full (full),
    .empty(empty)
  );

`ifdef TRACE_LOSS_MARK_EN
  logic loss_pend;

  always_ff @(posedge CLK) begin
    if (!RESET)    loss_pend <= 1'b0;
    else if (drop) loss_pend <= 1'b1;
    else if (pop)  loss_pend <= 1'b0;
  end

  assign sync_sel = loss_pend ? SYNC_LOSS : SYNC_OK;
`else
  assign sync_sel = SYNC_OK;
`endif

  // tx is registered, so the line trails the FSM state by one cycle
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      prev_state <= 3'd0;
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      sreg       <= '0;
      sync_q     <= SYNC_OK;
      tx         <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      prev_state <= state_in;
      state      <= state_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_d;
      byte_idx   <= byte_d;
      sreg       <= sreg_d;
      sync_q     <= sync_d;
      tx         <= tx_d;
      overflow   <= overflow | drop;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    byte_d  = byte_idx;
    sreg_d  = sreg;
    sync_d  = sync_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    if (state != S_IDLE) cnt_d = baud_end ? '0 : cnt + 1'b1;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sreg_d  = dout;
          sync_d  = sync_sel;
          byte_d  = 4'd0;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = cur_byte[bit_idx];
        if (baud_end) begin
          if (bit_idx == 3'd7) state_d = S_STOP;
          else                 bit_d   = bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          if (byte_idx < LAST_BYTE) begin
            byte_d  = byte_idx + 4'd1;
            state_d = S_START;
            if (byte_idx != 4'd0) sreg_d = {sreg[55:0], 8'h00};
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_riscv_trace_uart_tx.sv
// Bench for riscv_trace_uart_tx: frame-level model, per-cycle compare, UART receiver.
// Honors TRACE_LOSS_MARK_EN the same way as the design.
module tb_riscv_trace_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FL    = 90 * CPB;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [2:0]  state_in = 3'd0;
  logic [31:0] pc_in = 32'd0;
  logic [31:0] instr_in = 32'd0;
  logic        tx;
  logic        busy;
  logic        overflow;

  riscv_trace_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH),
    .EXEC_STATE  (3'd3)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .state_in(state_in),
    .pc_in   (pc_in),
    .instr_in(instr_in),
    .tx      (tx),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  // model state: k counts rising edges, e is the edge of the last pop
  longint      k = 0;
  longint      e = -1000000;
  longint      last_cap = 0;
  logic [63:0] m_rec = '0;
  logic [7:0]  m_sync = 8'hA5;
  logic [63:0] mq[$];
  logic [2:0]  m_prev = 3'd0;
  bit          m_ovf = 0;
  bit          m_loss = 0;
  bit          m_valid = 0;

  // receiver state
  bit          rx_act = 0;
  longint      rx_s = 0;
  logic [7:0]  rx_b = '0;
  logic [7:0]  rxq[$];
  longint      rxk[$];

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, k);
  endtask

  function automatic logic exp_tx(longint kk);
    int idx, b, bn;
    logic [7:0] byt;
    if (kk < e + 1 || kk > e + FL) return 1'b1;
    idx = int'(kk - e - 1) / CPB;
    b   = idx / 10;
    bn  = idx % 10;
    if (bn == 0) return 1'b0;
    if (bn == 9) return 1'b1;
    byt = (b == 0) ? m_sync : m_rec[63 - 8*(b-1) -: 8];
    return byt[bn-1];
  endfunction

  initial forever begin
    int sz;
    bit mpop;
    @(posedge CLK);
    k++;
    if (!RESET) begin
      mq.delete();
      m_ovf   = 0;
      m_loss  = 0;
      m_prev  = 3'd0;
      e       = -1000000;
      m_valid = 1;
    end else begin
      sz   = mq.size();
      mpop = (k > e + FL) && (sz > 0);
      if (mpop) begin
        m_rec = mq.pop_front();
        e     = k;
`ifdef TRACE_LOSS_MARK_EN
        m_sync = m_loss ? 8'h5A : 8'hA5;
        m_loss = 0;
`else
        m_sync = 8'hA5;
`endif
      end
      if (state_in == 3'd3 && m_prev != 3'd3) begin
        last_cap = k;
        if (sz == DEPTH && !mpop) begin
          m_ovf  = 1;
          m_loss = 1;
        end else begin
          mq.push_back({pc_in, instr_in});
        end
      end
      m_prev = state_in;
    end
  end

  initial forever begin
    @(negedge CLK);
    if (m_valid) begin
      check("tx", tx, exp_tx(k));
      check("busy", busy, (k >= e && k < e + FL));
      check("overflow", overflow, m_ovf);
    end
  end

  initial forever begin
    @(negedge CLK);
    if (!RESET) begin
      rx_act = 0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1;
        rx_s   = k;
      end
    end else begin
      for (int i = 0; i < 8; i++)
        if (k == rx_s + CPB*(1+i) + CPB/2) rx_b[i] = tx;
      if (k == rx_s + 9*CPB + CPB/2) begin
        check("rx_stop", tx, 1);
        rxq.push_back(rx_b);
        rxk.push_back(rx_s);
        rx_act = 0;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic capture(logic [31:0] pc, logic [31:0] ins);
    @(negedge CLK);
    state_in = 3'd3;
    pc_in    = pc;
    instr_in = ins;
    @(negedge CLK);
    state_in = 3'd2;
  endtask

  task automatic wait_bytes(int n, int limit, string name);
    int t = 0;
    while (rxq.size() < n && t < limit) begin
      @(negedge CLK);
      t++;
    end
    check(name, rxq.size() >= n, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s2 [9];
    logic [7:0] sy;
    s2 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'hA0, 8'h00, 8'h93};

    RESET = 1'b0;
    cyc(2);
    RESET = 1'b1;
    cyc(10);
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);
    check("idle_ovf", overflow, 0);

    // single capture with steady EXEC state
    state_in = 3'd2;
    cyc(2);
    @(negedge CLK);
    state_in = 3'd3;
    pc_in    = 32'h0000_0010;
    instr_in = 32'h00A0_0093;
    cyc(20);
    state_in = 3'd2;
    wait_bytes(9, 500, "s2_wait");
    cyc(20);
    check("s2_nbytes", rxq.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < rxq.size()) check("s2_byte", rxq[i], s2[i]);
    if (rxk.size() >= 9) begin
      check("s2_latency", rxk[0] - last_cap, 2);
      check("s2_len", rxk[8] + 10*CPB - rxk[0], 360);
    end

    // six captures 10 cycles apart, sixth dropped
    rxq.delete();
    rxk.delete();
    for (int i = 0; i < 6; i++) begin
      capture(32'h100 + 32'(4*i), 32'h0010_0013 + 32'(i));
      if (i < 5) cyc(8);
    end
    check("s3_ovf", overflow, 1);
    wait_bytes(45, 5*361 + 200, "s3_wait");
    cyc(50);
    check("s3_nbytes", rxq.size(), 45);
    if (rxq.size() >= 45) begin
      for (int j = 0; j < 5; j++) begin
`ifdef TRACE_LOSS_MARK_EN
        sy = (j == 1) ? 8'h5A : 8'hA5;
`else
        sy = 8'hA5;
`endif
        check("s3_sync", rxq[9*j], sy);
        check("s3_pc", {rxq[9*j+1], rxq[9*j+2], rxq[9*j+3], rxq[9*j+4]},
              32'h100 + 32'(4*j));
      end
      for (int j = 0; j < 4; j++)
        check("s3_gap", rxk[9*(j+1)] - rxk[9*j], 361);
    end

    // reset in the middle of byte 4
    rxq.delete();
    rxk.delete();
    capture(32'h0000_0200, 32'hDEAD_BEEF);
    wait_bytes(4, 400, "s4_wait");
    cyc(10);
    RESET = 1'b0;
    @(negedge CLK);
    check("s4_tx", tx, 1);
    check("s4_busy", busy, 0);
    check("s4_ovf", overflow, 0);
    RESET = 1'b1;
    rxq.delete();
    rxk.delete();
    cyc(400);
    check("s4_noresume", rxq.size(), 0);

    // capture on the same edge as an IDLE pop with the FIFO full
    for (int i = 0; i < 5; i++) begin
      capture(32'h300 + 32'(4*i), 32'h0000_0013);
      if (i < 4) cyc(8);
    end
    cyc(320);
    capture(32'h0000_0400, 32'h0000_0073);
    check("s5_ovf", overflow, 0);
    wait_bytes(54, 6*361 + 300, "s5_wait");
    cyc(50);
    check("s5_nbytes", rxq.size(), 54);
    if (rxq.size() >= 54)
      check("s5_last_pc", {rxq[46], rxq[47], rxq[48], rxq[49]}, 32'h0000_0400);
    check("s5_ovf_end", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
